uart_bus_bridge: RTL
====================

// Module: uart_bus_bridge
// PURPOSE
//  Host-command endpoint on the far side of the uart byte interface. Parses
//  byte frames from uart rx into 32-bit bus read/write transactions and returns
//  response bytes through uart tx. Sits between uart and the system bus as a
//  debug/loader port.
// PARAMETERS
//  TIMEOUT_CYCLES  1_000_000  max idle cycles between bytes inside a frame before abort
//  (localparam TIMEOUT_WIDTH = `GET_WIDTH(TIMEOUT_CYCLES))
// PORTS
//  clk        in   1   system clock; all logic on posedge
//  rst        in   1   reset, asynchronous, active-high
//  rx_data    in   8   received byte, valid when rx_valid=1
//  rx_valid   in   1   one-cycle pulse per received byte
//  tx_data    out  8   byte to transmit; stable while tx_send=1
//  tx_send    out  1   transmit request level, held until tx_sent
//  tx_sent    in   1   one-cycle pulse: current byte's stop bit finished
//  bus_addr   out  32  transaction address
//  bus_wdata  out  32  write data
//  bus_we     out  1   1=write, 0=read; valid while bus_req=1
//  bus_req    out  1   transaction request, held until bus_ack
//  bus_rdata  in   32  read data, sampled on cycle bus_ack=1
//  bus_ack    in   1   one-cycle completion pulse
//  busy       out  1   1 in any state except IDLE
//  frame_err  out  1   one-cycle pulse on bad opcode or inter-byte timeout
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0. Reset mid-transaction drops
//   bus_req/tx_send immediately; partial frame discarded, no response.
//  Frame: opcode, 4 addr bytes LSB first, then (W only) 4 data bytes LSB first.
//   0x57 'W' = write, 0x52 'R' = read; any other opcode is illegal.
//  States: IDLE -> ADDR(idx 0..3) -> [WDATA(idx 0..3) if W] -> BUS -> SEND -> IDLE.
//  IDLE: on rx_valid: W/R -> ADDR, idx=0; illegal -> SEND with '?' (0x3F),
//   frame_err pulse next cycle.
//  ADDR/WDATA: each rx_valid stores byte at idx, idx++; after idx 3 advance.
//  Timeout: counter cleared on every rx_valid, increments in ADDR/WDATA; on
//   reaching TIMEOUT_CYCLES-1 -> IDLE, frame_err pulse, no response byte.
//   rx_valid in the same cycle as expiry wins (byte taken, counter cleared).
//  BUS: bus_req rises the cycle after the final frame byte's rx_valid;
//   addr/wdata/we stable while req=1. On bus_ack: bus_req low next cycle,
//   rdata latched (R). No bus timeout; waits indefinitely.
//  SEND: tx_send rises the cycle after bus_ack (or after illegal opcode).
//   W -> 1 byte 'K' (0x4B); R -> 4 bytes rdata[7:0],[15:8],[23:16],[31:24].
//   tx_send held with tx_data stable until tx_sent=1; deasserted that edge;
//   next byte's tx_send asserted the following cycle. After last tx_sent -> IDLE.
//  rx_valid while in BUS or SEND is ignored (byte dropped, no error).
//  tx_sent while tx_send=0 is ignored. bus_ack while bus_req=0 is ignored.
// TESTING
//  1 rx 57 10 00 00 80 EF BE AD DE -> one bus_req we=1 addr=0x80000010
//    wdata=0xDEADBEEF; ack -> tx byte 0x4B; busy low after its tx_sent.
//  2 rx 52 04 00 00 00, bus_rdata=0x12345678 on ack -> tx 78,56,34,12 in
//    order, each tx_send held until tx_sent; bus_req exactly one transaction.
//  3 rx 0x41 -> frame_err pulse, tx 0x3F, no bus_req; next rx 52.. works.
//  4 rx 52 01 then silence TIMEOUT_CYCLES (bench param 100) -> frame_err at
//    cycle 99 after last byte, IDLE, no tx; fresh frame then completes.
//  5 assert rst while bus_req=1 -> bus_req, tx_send, busy 0 immediately;
//    late bus_ack ignored; no tx bytes emitted.
//  6 rx bytes injected during SEND of test 2 -> ignored, response unchanged,
//    bridge returns IDLE and accepts the next frame correctly.

Source files
------------

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: turns framed host command bytes from the uart receiver
// into single 32-bit bus reads/writes and returns the response bytes through
// the uart transmitter.
//   Write frame: 'W' a0 a1 a2 a3 d0 d1 d2 d3 -> response 'K'
//   Read frame : 'R' a0 a1 a2 a3             -> response r0 r1 r2 r3
//   Any other opcode -> response '?' plus a frame_err pulse.
// Address and data bytes arrive least significant byte first.
module uart_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  input  logic        tx_sent,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  output logic        bus_req,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        busy,
  output logic        frame_err
);

  localparam int TIMEOUT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  // The abort fires on the edge where the idle count would reach
  // TIMEOUT_CYCLES-1, so the compare is made against the value one below it.
  localparam logic [TIMEOUT_WIDTH-1:0] TIMER_ABORT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 2);

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_BAD  = 8'h3F;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    BUS   = 3'd3,
    SEND  = 3'd4
  } state_t;

  state_t                   state_reg, state_next;
  logic [1:0]               idx_reg, idx_next;
  logic [1:0]               byte_cnt_reg, byte_cnt_next;
  logic [TIMEOUT_WIDTH-1:0] timer_reg, timer_next;
  logic [31:0]              addr_reg, addr_next;
  logic [31:0]              wdata_reg, wdata_next;
  logic [31:0]              rdata_reg, rdata_next;
  logic                     we_reg, we_next;
  logic                     err_resp_reg, err_resp_next;
  logic                     tx_send_reg, tx_send_next;
  logic                     frame_err_reg, frame_err_next;
  logic                     last_byte;

  // Write and illegal-opcode responses are one byte; reads return four.
  assign last_byte = (err_resp_reg || we_reg) ? 1'b1 : (byte_cnt_reg == 2'd3);

  // State and datapath registers; reset abandons any partial frame at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      byte_cnt_reg  <= '0;
      timer_reg     <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      we_reg        <= 1'b0;
      err_resp_reg  <= 1'b0;
      tx_send_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      byte_cnt_reg  <= byte_cnt_next;
      timer_reg     <= timer_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      rdata_reg     <= rdata_next;
      we_reg        <= we_next;
      err_resp_reg  <= err_resp_next;
      tx_send_reg   <= tx_send_next;
      frame_err_reg <= frame_err_next;
    end
  end

  // Next-state logic: frame parsing, inter-byte timeout, bus and tx handshakes.
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    byte_cnt_next  = byte_cnt_reg;
    timer_next     = timer_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    rdata_next     = rdata_reg;
    we_next        = we_reg;
    err_resp_next  = err_resp_reg;
    tx_send_next   = tx_send_reg;
    frame_err_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        timer_next = '0;
        if (rx_valid) begin
          if (rx_data == OP_WRITE || rx_data == OP_READ) begin
            state_next    = ADDR;
            idx_next      = 2'd0;
            we_next       = (rx_data == OP_WRITE);
            err_resp_next = 1'b0;
          end else begin
            state_next     = SEND;
            err_resp_next  = 1'b1;
            byte_cnt_next  = 2'd0;
            tx_send_next   = 1'b1;
            frame_err_next = 1'b1;
          end
        end
      end

      ADDR, WDATA: begin
        if (rx_valid) begin
          // A byte arriving on the expiry cycle still counts.
          timer_next = '0;
          idx_next   = idx_reg + 2'd1;
          if (state_reg == ADDR) begin
            addr_next[{idx_reg, 3'b000} +: 8] = rx_data;
          end else begin
            wdata_next[{idx_reg, 3'b000} +: 8] = rx_data;
          end
          if (idx_reg == 2'd3) begin
            idx_next   = 2'd0;
            state_next = (state_reg == ADDR && we_reg) ? WDATA : BUS;
          end
        end else if (timer_reg == TIMER_ABORT) begin
          state_next     = IDLE;
          idx_next       = 2'd0;
          timer_next     = '0;
          frame_err_next = 1'b1;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      BUS: begin
        if (bus_ack) begin
          rdata_next    = bus_rdata;
          state_next    = SEND;
          byte_cnt_next = 2'd0;
          tx_send_next  = 1'b1;
        end
      end

      SEND: begin
        if (tx_send_reg) begin
          if (tx_sent) begin
            tx_send_next = 1'b0;
            if (last_byte) begin
              state_next    = IDLE;
              byte_cnt_next = 2'd0;
            end else begin
              byte_cnt_next = byte_cnt_reg + 2'd1;
            end
          end
        end else begin
          // One idle cycle between bytes, then request the next one.
          tx_send_next = 1'b1;
        end
      end

      default: begin
        state_next   = IDLE;
        tx_send_next = 1'b0;
      end
    endcase
  end

  // Outputs decoded from registered state so they never glitch on inputs.
  always_comb begin
    bus_req   = (state_reg == BUS);
    bus_addr  = addr_reg;
    bus_wdata = wdata_reg;
    bus_we    = we_reg && (state_reg == BUS);
    busy      = (state_reg != IDLE);
    tx_send   = tx_send_reg;
    frame_err = frame_err_reg;
    tx_data   = 8'h00;
    if (state_reg == SEND) begin
      if (err_resp_reg) begin
        tx_data = RSP_BAD;
      end else if (we_reg) begin
        tx_data = RSP_OK;
      end else begin
        tx_data = rdata_reg[{byte_cnt_reg, 3'b000} +: 8];
      end
    end
  end

endmodule
